ps2_kbd_ctrl: RTL and testbench
===============================

# ps2_kbd_ctrl

PS/2 keyboard receiver for the zhxpu board. It decodes 11-bit PS/2 frames from the keyboard pins, checks them, and buffers the received scan codes in a small FIFO. It also provides a status/data read port using the same `need_to_work`/`work_done` handshake the memory controller already uses for RAM1/UART. The memory controller calls this block when the EXE stage reads the keyboard data or status addresses.

## Interface
- `FIFO_DEPTH`, default 8: scan-code FIFO entries; power of two, 2..16.
- `FILTER`, default 4: consecutive equal synchronized samples required before `ps2_clk` changes its filtered level.
- `TIMEOUT`, default 100000: clk cycles without a filtered falling edge before a partial frame is aborted (2 ms at 50 MHz).
- `clk`  in  1  system clock (raw_clk domain).
- `rst`  in  1  reset; asynchronous, active-low.
- `ps2_clk`  in  1  raw keyboard clock; asynchronous.
- `ps2_data`  in  1  raw keyboard data; asynchronous.
- `need_to_work`  in  1  read request from the memory controller; held high until `work_done` is seen.
- `sel`  in  1  read select: 0 = data, 1 = status; stable while `need_to_work` is high.
- `work_done`  out  1  read complete; `result` is valid while this is high.
- `result`  out  16  read data.
- `data_avail`  out  1  FIFO non-empty; usable as an interrupt or poll bit.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through two sync flops, reset to 1.
  - The filtered clock level changes only after `FILTER` equal synchronized samples.
  - A filtered 1→0 transition is a sample event; `ps2_data` is sampled from its synced value at that event.
- **Frame FSM**
  - IDLE: on a sample event with data 0 (start bit), go to DATA with bit count 0. Data 1 is ignored.
  - DATA: shift 8 bits LSB first, then go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: the frame is good if the XOR of 8 data bits and the parity bit is 1 (odd parity) and the stop bit is 1.
    - Good frame: push the byte.
    - Bad frame: drop the byte and set sticky `frame_err`.
    - Either way, return to IDLE.
- **Timeout**
  - A counter runs in every state except IDLE and clears on each sample event.
  - When it reaches `TIMEOUT`, the FSM returns to IDLE and sets `frame_err`. No push occurs.
- **FIFO**
  - Circular buffer with read/write pointers and a count of width log2(`FIFO_DEPTH`)+1.
  - Push while full and not popping in the same cycle: the new byte is dropped and sticky `overflow` is set.
  - Push and pop in the same cycle: both succeed, including when full; count is unchanged.
- **Read port**
  - Data read: `result` = {8'h00, head byte}, and one pop occurs per transaction.
  - Data read while empty: `result` = 16'h0000, no pop.
  - Status read returns:
    - bit0: non-empty
    - bit1: full
    - bit2: `overflow`
    - bit3: `frame_err`
    - bits[8:4]: count
    - all other bits 0
  - A status read clears `overflow` and `frame_err`. If a set and this clear hit the same cycle, the set wins.

## Timing
- Reset values: `work_done` 0, `result` 0, `data_avail` 0, FSM IDLE, FIFO empty, sticky bits 0, timeout counter 0.
- Reset mid-frame discards the partial frame and all FIFO contents.
- Sample-event latency: 2 + `FILTER` cycles after the raw `ps2_clk` falls.
- Push latency: the push occurs on the clock edge after the stop-bit sample event. `data_avail` is registered and rises at that same edge.
- Handshake:
  - `need_to_work` is sampled high while `work_done` = 0.
  - At the next edge, `work_done` = 1, `result` is loaded, and the pop/clear is applied. This is a one-cycle latency.
  - `work_done` stays high and `result` stays frozen while `need_to_work` stays high.
  - `work_done` drops at the first edge after `need_to_work` is sampled low.
  - A new transaction needs at least one cycle with `need_to_work` low.

## Structure
- The shared include `define.v` gets the FSM state encodings (IDLE/DATA/PARITY/STOP) and the status bit positions. The memory controller needs the status bit positions.
- The natural sub-module is `ps2_fifo`: a synchronous FIFO with push/pop/full/empty/count, async active-low reset, parameterized by `FIFO_DEPTH`.
- The FSM, filter, timeout and read port stay in `ps2_kbd_ctrl`.

## Test plan
- **Good frame 0x1C:** start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1, bit period 3000 cycles. Expect `data_avail` to rise 2+`FILTER`+1 cycles after the stop falling edge. Then a data read returns `result` = 16'h001C, and `data_avail` falls at the `work_done` edge.
- **Parity error:** send 0xF0 with parity 0. Expect no push. Status read returns 16'h0008. A second status read returns 16'h0000.
- **Overflow:** with `FIFO_DEPTH`=8, send 9 good frames 0x01..0x09. Status returns count 8, full, and overflow, i.e. 16'h0086. Eight data reads return 0x01..0x08; a ninth returns 16'h0000.
- **Timeout:** send start plus 3 data bits, then idle for `TIMEOUT`+10 cycles. Expect frame_err set and the FSM back in IDLE. A following good 0x5A frame is received correctly.
- **Simultaneous push/pop:** with the FIFO full, issue a data read timed to the same cycle as a push of 0x33. Expect count to stay 8, overflow to stay 0, and the last entry to be 0x33.
- **Reset and glitches:** assert `rst` low mid-frame and mid-handshake; expect all outputs to go to 0 immediately. Inject a glitch on `ps2_clk` shorter than `FILTER` cycles; expect no sample event.

Source files
------------

// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encodings and
// the status word layout the memory controller decodes.
package ps2_kbd_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int STAT_NONEMPTY  = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 5;

    typedef struct packed {
        logic [6:0] rsvd;
        logic [4:0] count;
        logic       frame_err;
        logic       overflow;
        logic       full;
        logic       nonempty;
    } status_t;

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code FIFO: circular buffer with registered full/empty flags; a push
// into a full FIFO succeeds only when a pop happens in the same cycle.
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop & ~empty_q;
        do_push  = push & (~full_q | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        empty_d  = (count_d == '0);
        full_d   = (count_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: conditions the raw pins, decodes 11-bit frames,
// buffers good scan codes and serves data/status reads over need_to_work/work_done.
module ps2_kbd_ctrl
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER     = 4,
    parameter int TIMEOUT    = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        need_to_work,
    input  logic        sel,
    output logic        work_done,
    output logic [15:0] result,
    output logic        data_avail,
    output logic [1:0]  dbg_state
);
    localparam int FCW = $clog2(FILTER + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           samp_evt;
    logic [1:0]     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           push_q, push_d;
    logic           ferr_q, ferr_d, ferr_set;
    logic           ovf_q, ovf_d, ovf_set;
    logic           work_done_q, work_done_d;
    logic [15:0]    result_q, result_d;
    logic           rd_fire, pop, stat_clr;
    logic [7:0]     fifo_rdata;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    status_t        status;

    // The filtered level only moves after FILTER consecutive disagreeing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FCW'(FILTER - 1)) filt_d = clk_s2_q;
            else                                filt_cnt_d = filt_cnt_q + 1'b1;
        end
        samp_evt = filt_q & ~filt_d;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push_d    = 1'b0;
        ferr_set  = 1'b0;
        to_cnt_d  = (state_q == ST_IDLE || samp_evt) ? '0 : to_cnt_q + 1'b1;
        if (samp_evt) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if ((^shift_q ^ par_q) && dat_s2_q) push_d   = 1'b1;
                    else                                ferr_set = 1'b1;
                end
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q >= TW'(TIMEOUT)) begin
            state_d  = ST_IDLE;
            to_cnt_d = '0;
            ferr_set = 1'b1;
        end
    end

    always_comb begin
        status           = '0;
        status.count     = 5'(fifo_count);
        status.frame_err = ferr_q;
        status.overflow  = ovf_q;
        status.full      = fifo_full;
        status.nonempty  = ~fifo_empty;

        rd_fire     = need_to_work & ~work_done_q;
        pop         = rd_fire & ~sel & ~fifo_empty;
        stat_clr    = rd_fire & sel;
        work_done_d = work_done_q ? need_to_work : rd_fire;
        result_d    = result_q;
        if (rd_fire) result_d = sel ? status : (fifo_empty ? 16'h0000 : {8'h00, fifo_rdata});

        // A flag raised in the same cycle as a status-read clear survives it.
        ovf_set = push_q & fifo_full & ~pop;
        ovf_d   = ovf_set | (ovf_q & ~stat_clr);
        ferr_d  = ferr_set | (ferr_q & ~stat_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            push_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            work_done_q <= 1'b0;
            result_q    <= 16'h0000;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            push_q      <= push_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
            work_done_q <= work_done_d;
            result_q    <= result_d;
        end
    end

    // shift_q holds the byte until the next frame's data bits, well after the push.
    ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push_q),
        .pop   (pop),
        .wdata (shift_q),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign work_done  = work_done_q;
    assign result     = result_q;
    assign data_avail = ~fifo_empty;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl against a queue-based model of the
// keyboard buffer and its sticky status flags.
module tb_ps2_kbd_ctrl;
    import ps2_kbd_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int FILT  = 4;
    localparam int TMO   = 4000;
    localparam int HALF  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        need_to_work = 1'b0;
    logic        sel = 1'b0;
    logic        work_done;
    logic [15:0] result;
    logic        data_avail;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    bit         m_ovf = 1'b0;
    bit         m_ferr = 1'b0;

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .FILTER(FILT), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .need_to_work (need_to_work),
        .sel          (sel),
        .work_done    (work_done),
        .result       (result),
        .data_avail   (data_avail),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model ----------------
    function automatic void model_frame(input logic [7:0] b, input bit good);
        if (!good) m_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    function automatic logic [15:0] model_status_read();
        int n = exp_q.size();
        logic [15:0] s;
        s = {7'd0, 5'(n), m_ferr, m_ovf, (n == DEPTH), (n != 0)};
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        return s;
    endfunction

    function automatic logic [15:0] model_data_read();
        if (exp_q.size() == 0) return 16'h0000;
        return {8'h00, exp_q.pop_front()};
    endfunction

    // ---------------- drivers ----------------
    task automatic ps2_bit(input logic v, input int half);
        @(negedge clk);
        ps2_data = v;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] b, input bit bad_par, input int half);
        ps2_bit(1'b0, half);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
        ps2_bit((~^b) ^ bad_par, half);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int half);
        send_head(b, bad_par, half);
        ps2_bit(1'b1, half);
        repeat (FILT + 4) @(negedge clk);
    endtask

    task automatic do_read(input logic s, output logic [15:0] r, output int lat, output int drop);
        @(negedge clk);
        sel = s;
        need_to_work = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!work_done && lat < 20);
        if (!work_done) begin
            checks++;
            failures++;
            $display("FAIL read_handshake: work_done never rose (sel=%0d)", s);
        end
        r = result;
        need_to_work = 1'b0;
        drop = 0;
        do begin
            @(negedge clk);
            drop++;
        end while (work_done && drop < 20);
        if (work_done) begin
            checks++;
            failures++;
            $display("FAIL read_release: work_done stuck high");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({work_done, result, data_avail} !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs: wd=%b result=%h avail=%b want 0/0000/0", work_done, result, data_avail);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [15:0] r, e;
        int lat, drop;
        send_head(8'h1C, 1'b0, 1500);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (1500) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILT + 2) @(posedge clk);
        #1;
        checks++;
        if (data_avail !== 1'b0) begin
            failures++;
            $display("FAIL avail_early: got %b want 0", data_avail);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data_avail !== 1'b1) begin
            failures++;
            $display("FAIL avail_latency: got %b want 1", data_avail);
        end
        model_frame(8'h1C, 1'b1);
        repeat (1500) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);

        e = model_data_read();
        @(negedge clk);
        sel = 1'b0;
        need_to_work = 1'b1;
        @(negedge clk);
        checks++;
        if (work_done !== 1'b1 || result !== e || data_avail !== 1'b0) begin
            failures++;
            $display("FAIL data_read_1c: wd=%b result=%h avail=%b want 1/%h/0", work_done, result, data_avail, e);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (work_done !== 1'b1 || result !== e) begin
            failures++;
            $display("FAIL result_hold: wd=%b result=%h want 1/%h", work_done, result, e);
        end
        need_to_work = 1'b0;
        @(negedge clk);
        checks++;
        if (work_done !== 1'b0) begin
            failures++;
            $display("FAIL wd_drop: got %b want 0", work_done);
        end
        do_read(1'b0, r, lat, drop);
        e = model_data_read();
        checks++;
        if (r !== e || lat != 1 || drop != 1) begin
            failures++;
            $display("FAIL empty_read: result=%h lat=%0d drop=%0d want %h/1/1", r, lat, drop, e);
        end
    endtask

    task automatic test_parity_err();
        logic [15:0] r, e;
        int lat, drop;
        send_frame(8'hF0, 1'b1, HALF);
        model_frame(8'hF0, 1'b0);
        checks++;
        if (data_avail !== 1'b0) begin
            failures++;
            $display("FAIL parity_no_push: avail=%b want 0", data_avail);
        end
        for (int k = 0; k < 2; k++) begin
            do_read(1'b1, r, lat, drop);
            e = model_status_read();
            checks++;
            if (r !== e) begin
                failures++;
                $display("FAIL parity_status%0d: got %h want %h", k, r, e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] r, e;
        int lat, drop;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, HALF);
            model_frame(8'(i), 1'b1);
        end
        do_read(1'b1, r, lat, drop);
        e = model_status_read();
        checks++;
        if (r !== e) begin
            failures++;
            $display("FAIL ovf_status: got %h want %h", r, e);
        end
        for (int i = 0; i < 9; i++) begin
            do_read(1'b0, r, lat, drop);
            e = model_data_read();
            checks++;
            if (r !== e) begin
                failures++;
                $display("FAIL ovf_drain%0d: got %h want %h", i, r, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [15:0] r, e;
        int lat, drop;
        ps2_bit(1'b0, HALF);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, HALF);
        checks++;
        if (dbg_state !== ST_DATA) begin
            failures++;
            $display("FAIL partial_state: got %0d want %0d", dbg_state, ST_DATA);
        end
        repeat (TMO + 10) @(negedge clk);
        m_ferr = 1'b1;
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL timeout_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
        do_read(1'b1, r, lat, drop);
        e = model_status_read();
        checks++;
        if (r !== e) begin
            failures++;
            $display("FAIL timeout_status: got %h want %h", r, e);
        end
        send_frame(8'h5A, 1'b0, HALF);
        model_frame(8'h5A, 1'b1);
        do_read(1'b0, r, lat, drop);
        e = model_data_read();
        checks++;
        if (r !== e) begin
            failures++;
            $display("FAIL after_timeout: got %h want %h", r, e);
        end
    endtask

    task automatic test_push_pop();
        logic [15:0] r, e;
        int lat, drop;
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h40 + 8'(i), 1'b0, HALF);
            model_frame(8'h40 + 8'(i), 1'b1);
        end
        send_head(8'h33, 1'b0, HALF);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILT + 2) @(posedge clk);
        #1;
        sel = 1'b0;
        need_to_work = 1'b1;
        // Pop and push land on the same edge, so the model pops first.
        e = model_data_read();
        exp_q.push_back(8'h33);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (work_done !== 1'b1 || result !== e) begin
            failures++;
            $display("FAIL pushpop_read: wd=%b result=%h want 1/%h", work_done, result, e);
        end
        need_to_work = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        do_read(1'b1, r, lat, drop);
        e = model_status_read();
        checks++;
        if (r !== e) begin
            failures++;
            $display("FAIL pushpop_status: got %h want %h", r, e);
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_read(1'b0, r, lat, drop);
            e = model_data_read();
            checks++;
            if (r !== e) begin
                failures++;
                $display("FAIL pushpop_drain%0d: got %h want %h", i, r, e);
            end
        end
    endtask

    task automatic test_reset_glitch();
        logic [15:0] r, e;
        int lat, drop;
        send_frame(8'h77, 1'b0, HALF);
        model_frame(8'h77, 1'b1);
        @(negedge clk);
        sel = 1'b1;
        need_to_work = 1'b1;
        e = model_status_read();
        repeat (2) @(negedge clk);
        checks++;
        if (work_done !== 1'b1 || result !== e) begin
            failures++;
            $display("FAIL pre_reset_status: wd=%b result=%h want 1/%h", work_done, result, e);
        end
        ps2_bit(1'b0, HALF);
        ps2_bit(1'b1, HALF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({work_done, result, data_avail} !== 18'h0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL async_reset: wd=%b result=%h avail=%b state=%0d want all 0", work_done, result, data_avail, dbg_state);
        end
        need_to_work = 1'b0;
        sel = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        m_ferr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_read(1'b1, r, lat, drop);
        e = model_status_read();
        checks++;
        if (r !== e) begin
            failures++;
            $display("FAIL post_reset_status: got %h want %h", r, e);
        end
        ps2_data = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILT - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL glitch_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
        send_frame(8'hA5, 1'b0, HALF);
        model_frame(8'hA5, 1'b1);
        do_read(1'b0, r, lat, drop);
        e = model_data_read();
        checks++;
        if (r !== e) begin
            failures++;
            $display("FAIL glitch_frame: got %h want %h", r, e);
        end
    endtask

    task automatic test_random();
        logic [15:0] r, e;
        logic [7:0]  b;
        bit          bad;
        int lat, drop, op;
        for (int i = 0; i < 14; i++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            send_frame(b, bad, HALF);
            model_frame(b, !bad);
            op = $urandom_range(0, 9);
            if (op < 4) begin
                do_read(1'b0, r, lat, drop);
                e = model_data_read();
                checks++;
                if (r !== e) begin
                    failures++;
                    $display("FAIL rand_data%0d: got %h want %h", i, r, e);
                end
            end else if (op < 6) begin
                do_read(1'b1, r, lat, drop);
                e = model_status_read();
                checks++;
                if (r !== e) begin
                    failures++;
                    $display("FAIL rand_status%0d: got %h want %h", i, r, e);
                end
            end
        end
        do_read(1'b1, r, lat, drop);
        e = model_status_read();
        checks++;
        if (r !== e) begin
            failures++;
            $display("FAIL rand_final_status: got %h want %h", r, e);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            do_read(1'b0, r, lat, drop);
            e = model_data_read();
            checks++;
            if (r !== e) begin
                failures++;
                $display("FAIL rand_drain%0d: got %h want %h", i, r, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_overflow();
        test_timeout();
        test_push_pop();
        test_reset_glitch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
